// File: rtl/packer_pkg.sv
// Types shared by the byte-to-word packer and its output FIFO.
package packer_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef logic [2:0] bcount_t;

  typedef struct packed {
    int      data;
    bcount_t count;
    logic    last;
  } pword_t;

endpackage

// File: rtl/pword_fifo.sv
// Circular-buffer FIFO of packed words; pointers wrap modulo OUT_DEPTH.
module pword_fifo
  import packer_pkg::*;
#(
  parameter int OUT_DEPTH = 2,
  localparam int CW = $clog2(OUT_DEPTH + 1),
  localparam int PW = $clog2(OUT_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  pword_t        din,
  input  logic          pop,
  output pword_t        head,
  output logic [CW-1:0] count,
  output logic          full
);

  localparam logic [1:0] F_EMPTY   = 2'd0;
  localparam logic [1:0] F_PARTIAL = 2'd1;
  localparam logic [1:0] F_FULL    = 2'd2;

  pword_t        mem [OUT_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [1:0]    fstate;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    fstate = F_PARTIAL;
    if (count == '0)
      fstate = F_EMPTY;
    else if (count == CW'(OUT_DEPTH))
      fstate = F_FULL;
  end

  assign full = (fstate == F_FULL);
  assign head = mem[rptr];

  // storage carries no reset; validity is tracked by count alone
  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)
        wptr <= ptr_next(wptr);
      if (pop)
        rptr <= ptr_next(rptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/byte_word_packer.sv
// Assembles signed bytes little-endian into 32-bit words; in_last closes a
// partial word, sign-extended from its highest real byte.
module byte_word_packer
  import packer_pkg::*;
#(
  parameter int OUT_DEPTH      = 2,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [7:0]  in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] out_data,
  output logic [2:0]         out_count,
  output logic               out_last
);

  localparam int CW = $clog2(OUT_DEPTH + 1);

  if (BYTES_PER_WORD != packer_pkg::BYTES_PER_WORD) begin : g_bpw_chk
    $error("byte_word_packer: BYTES_PER_WORD must be 4");
  end
  if (OUT_DEPTH < 2 || OUT_DEPTH > 8) begin : g_depth_chk
    $error("byte_word_packer: OUT_DEPTH must be in 2..8");
  end

  logic signed [31:0] acc;
  logic [1:0]         idx;
  logic               rdy_en;
  logic               accept;
  logic               close;
  logic               fifo_full;
  logic [CW-1:0]      fifo_count;
  pword_t             push_word;
  pword_t             head;

  // Merge the current byte at idx; on a last byte, bytes above it copy its sign.
  function automatic logic signed [31:0] pad_word(input logic signed [31:0] a,
                                                  input logic signed [7:0]  b,
                                                  input logic [1:0]         i,
                                                  input logic               l);
    logic signed [31:0] w;
    w = a;
    w[8*i +: 8] = b;
    if (l) begin
      for (int k = 0; k < 4; k++) begin
        if (k > int'(i))
          w[8*k +: 8] = {8{b[7]}};
      end
    end
    return w;
  endfunction

  assign in_ready  = rdy_en && !fifo_full;
  assign accept    = in_valid && in_ready;
  assign close     = accept && ((idx == 2'd3) || in_last);
  assign out_valid = (fifo_count != '0);

  always_comb begin
    push_word       = '0;
    push_word.data  = pad_word(acc, in_data, idx, in_last);
    push_word.count = {1'b0, idx} + 3'd1;
    push_word.last  = in_last;
  end

  // assembly stage: idx==0 is IDLE, idx 1..3 is FILL
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      idx    <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (close) begin
        acc <= '0;
        idx <= '0;
      end else if (accept) begin
        acc[8*idx +: 8] <= in_data;
        idx             <= idx + 2'd1;
      end
    end
  end

  pword_fifo #(.OUT_DEPTH(OUT_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (close),
    .din   (push_word),
    .pop   (out_valid && out_ready),
    .head  (head),
    .count (fifo_count),
    .full  (fifo_full)
  );

  // outputs read as zero whenever the FIFO is empty, including after reset
  assign out_data  = out_valid ? head.data  : '0;
  assign out_count = out_valid ? head.count : '0;
  assign out_last  = out_valid ? head.last  : 1'b0;

endmodule

// File: doc/byte_word_packer.md
# byte_word_packer

Packs the signed byte stream produced by the integer-to-byte narrowing stage into 32-bit `int` words for the downstream word-consuming stage. Sits directly downstream of the narrowing stage: accepts one `byte` per valid/ready transfer, assembles four bytes little-endian, and emits each word through a small output FIFO. A `last` marker forces a partial word out, sign-extended from its highest real byte.

## Interface
- `OUT_DEPTH`, default 2: output FIFO entries (legal 2..8).
- `BYTES_PER_WORD`, default 4: fixed at 4. Elaboration error otherwise.

- `clk` in, 1: single clock; all logic on the rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `in_valid` in, 1: upstream byte valid.
- `in_ready` out, 1: block can accept a byte this cycle.
- `in_data` in, `byte`: signed input byte.
- `in_last` in, 1: byte is the final byte of a packet; closes the current word.
- `out_valid` out, 1: FIFO head valid.
- `out_ready` in, 1: downstream accepts the head.
- `out_data` out, `int`: packed word.
- `out_count` out, 3: real bytes in `out_data`, 1..4.
- `out_last` out, 1: word closed by `in_last`.

## Operation
- Input transfer: `in_valid && in_ready`. Output transfer: `out_valid && out_ready`.
- Assembly register: `acc[31:0]` and byte index `idx[1:0]`. An accepted byte writes `acc[8*idx +: 8]`, then `idx` increments.
- A word closes when the accepted byte has `idx==3` or `in_last==1`. The same cycle:
  - the word is pushed into the FIFO;
  - `idx` returns to 0 and `acc` clears.
- Pushed word: the completed `acc` with the current byte merged in.
  - Partial word (`in_last` with `idx<3`): bytes above the current byte take the sign of the current byte's bit 7. Example: one byte `8'h80` with last gives `32'hFFFF_FF80`.
  - `out_count = idx+1`.
  - `out_last = in_last`. A 4th byte with `in_last` gives count 4 and last 1.
- `in_ready = (fifo_count < OUT_DEPTH)`. It is based on the registered count only; a same-cycle pop does not free a slot.
- Only bytes that close a word push. Other bytes are still gated by `in_ready` to keep the rule simple.
- FIFO: circular buffer with read and write pointers wrapping modulo `OUT_DEPTH`.
  - Push and pop in the same cycle: both occur and the count is unchanged.
  - Pop when empty: impossible, since `out_valid=0`.
  - Push when full: impossible, since `in_ready=0`.
- FSM, tracked through `idx` plus the FIFO state:
  - `IDLE` (`idx==0`) moves to `FILL` (`idx` 1..3) on a non-closing byte.
  - `FILL` returns to `IDLE` on a closing byte.
  - FIFO state is `EMPTY`, `PARTIAL` or `FULL`, derived from `fifo_count`.
- Head data is stable while `out_valid && !out_ready`. Downstream must not observe the head changing.

## Timing
- Reset, applied in the cycle `rst` is sampled high:
  - `in_ready=0`, `out_valid=0`, `out_data=0`, `out_count=0`, `out_last=0`;
  - `acc`, `idx`, pointers and count all 0.
- First cycle after `rst` deasserts: `in_ready=1`.
- Reset mid-word drops the partial `acc` and all FIFO contents. No word is emitted.
- Latency: a word closed in cycle N appears on `out_valid`/`out_data` in cycle N+1, provided the FIFO was empty.
- Throughput: one byte per cycle while `out_ready` is held high. The output then sees one word every 4 cycles, and the FIFO never fills.
- A back-pressure stall is released by the first pop. `in_ready` rises in the cycle after that pop.
- `in_data` and `in_last` are ignored when `in_valid=0`.

## Structure
- Shared package `packer_pkg`:
  - `localparam int BYTES_PER_WORD = 4`;
  - `typedef logic [2:0] bcount_t`;
  - `typedef struct packed { int data; bcount_t count; logic last; } pword_t`.
- Sub-module `pword_fifo`: parameterised by `OUT_DEPTH`, stores `pword_t`, and exposes `full`, `count`, `push`, `pop` and `head`. The top level holds only the assembly register and the close/pad logic.

## Test plan
- Full word: after reset, send `8'h01,8'h02,8'h03,8'h04` with `out_ready=1` → one word `32'h0403_0201`, count 4, last 0, with `out_valid` one cycle after the 4th byte.
- Partial negative: send `8'h7F` then `8'hC0` with last → `32'hFFFF_C07F`, count 2, last 1.
- Partial positive: send single byte `8'h05` with last → `32'h0000_0005`, count 1, last 1.
- Back-pressure: with `OUT_DEPTH=2` and `out_ready=0`, send 12 bytes → `in_ready` drops after the 8th byte is accepted. Raise `out_ready` → words are popped in order and `in_ready` returns the next cycle. No loss and no duplication.
- Simultaneous push and pop: with the FIFO full and `out_ready=1`, no new byte is accepted until the count drops. With the count at 1, a push and a pop in the same cycle keep the count at 1.
- Reset mid-word: send `8'hAA,8'hBB`, assert `rst` for 1 cycle, then send `8'h11,8'h22,8'h33,8'h44` → the only word seen is `32'h4433_2211`.
